// File: rtl/matrix_vector_scheduler.sv
// Sequencer for a pipelined matrix-vector multiplier: holds the matrix, gathers a serial vector,
// waits out the multiplier latency and hands the captured result off on a valid/ready port.
module matrix_vector_scheduler #(
  parameter  int M_ROWS   = 3,
  parameter  int N_COLS   = 3,
  parameter  int DATA_W   = 3,
  parameter  int PIPE_LAT = 2,
  localparam int ACC_W    = 2*DATA_W + $clog2(N_COLS),
  localparam int ROW_W    = (M_ROWS > 1) ? $clog2(M_ROWS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             mat_we,
  input  logic [ROW_W-1:0]                 mat_row,
  input  logic [N_COLS*DATA_W-1:0]         mat_data,
  input  logic                             vec_valid,
  output logic                             vec_ready,
  input  logic [DATA_W-1:0]                vec_data,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [M_ROWS*ACC_W-1:0]          res_data,
  output logic [M_ROWS*N_COLS*DATA_W-1:0]  mvm_matrix,
  output logic [N_COLS*DATA_W-1:0]         mvm_vector,
  input  logic [M_ROWS*ACC_W-1:0]          mvm_result,
  output logic                             busy,
  output logic [15:0]                      jobs_done
);

  localparam int ROW_BITS = N_COLS*DATA_W;
  localparam int CNT_W    = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int WCNT_W   = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [CNT_W-1:0]  LAST_ELEM = CNT_W'(N_COLS-1);
  localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'(PIPE_LAT-1);
  localparam logic [ROW_W:0]    ROW_LIM   = (ROW_W+1)'(M_ROWS);

  typedef enum logic [1:0] {
    S_LOAD,
    S_WAIT,
    S_OUT
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_elem_cnt;
  logic [WCNT_W-1:0]  r_wait_cnt;
  logic               w_row_ok;

  assign w_row_ok  = ({1'b0, mat_row} < ROW_LIM);
  assign vec_ready = (r_state == S_LOAD);
  assign busy      = (r_state != S_LOAD);

  // NOTE: one clocked block with non-blocking assignments only; every register, the matrix
  // store included, is cleared by reset so an aborted job leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_LOAD;
      r_elem_cnt <= '0;
      r_wait_cnt <= '0;
      mvm_matrix <= '0;
      mvm_vector <= '0;
      res_data   <= '0;
      res_valid  <= 1'b0;
      jobs_done  <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (mat_we && w_row_ok) begin
            mvm_matrix[int'(mat_row)*ROW_BITS +: ROW_BITS] <= mat_data;
          end
          if (vec_valid) begin
            mvm_vector[int'(r_elem_cnt)*DATA_W +: DATA_W] <= vec_data;
            if (r_elem_cnt == LAST_ELEM) begin
              r_elem_cnt <= '0;
              r_wait_cnt <= WAIT_INIT;
              r_state    <= S_WAIT;
            end else begin
              r_elem_cnt <= r_elem_cnt + CNT_W'(1);
            end
          end
        end
        S_WAIT: begin
          // Operands stay frozen here so the multiplier output settles on this job.
          if (r_wait_cnt == '0) begin
            res_data  <= mvm_result;
            res_valid <= 1'b1;
            r_state   <= S_OUT;
          end else begin
            r_wait_cnt <= r_wait_cnt - WCNT_W'(1);
          end
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            jobs_done <= jobs_done + 16'd1;
            r_state   <= S_LOAD;
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule
